timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped down-counting timer that sits directly downstream of the system bridge.
- Two instances are used: TC0 at 0x7F00–0x7F0B and TC1 at 0x7F10–0x7F1B.
- The bridge drives word address, write data and a per-timer write enable; the block returns combinational read data and a level interrupt line to the CPU's external-interrupt input.

Parameters:
- CNT_W, 32: width of the PRESET and COUNT registers. Read bits above CNT_W return 0. Legal range 1–32.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- addr, input, 30: word address [31:2]; only addr[3:2] is decoded.
- we, input, 1: write strobe, already qualified by the bridge (full-word, in range).
- din, input, 32: write data.
- dout, output, 32: read data, combinational from addr[3:2].
- irq, output, 1: interrupt request = irq_flag & CTRL.IM.

Behaviour:
- Register map (addr[3:2]):
  - 0 = CTRL, read/write. Bit[0] EN, bits[2:1] MODE, bit[3] IM; bits[31:4] read 0, writes to them ignored.
  - 1 = PRESET, read/write.
  - 2 = COUNT, read-only; writes ignored.
  - 3 = reserved; reads 0, writes ignored.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Hence dout=0 (for any addr) and irq=0.
- FSM, 2-bit, states IDLE, LOAD, CNT, INT:
  - IDLE: if EN, go to LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN: go to IDLE, COUNT frozen.
    - Else if COUNT > 1: COUNT <= COUNT-1.
    - Else (COUNT is 1 or 0): COUNT <= 0, irq_flag <= 1, go to INT.
  - INT:
    - MODE=0 (one-shot): EN <= 0; irq_flag stays set; go to IDLE.
    - MODE=1 (auto-reload): irq_flag <= 0; go to IDLE, which reloads next cycle because EN is still 1.
    - MODE=2 and MODE=3 behave exactly as MODE=0.
- Timing, with the CTRL write committed at edge E0 and PRESET=N≥1:
  - E1: LOAD.
  - E2: COUNT=N.
  - E(k+2): COUNT=N-k, for k = 1 .. N-1.
  - E(N+2): COUNT=0, irq_flag=1.
  - PRESET=0 behaves like PRESET=1: the flag sets at E3.
  - Mode-1 period is N+3 cycles; irq is high for exactly 1 cycle per period.
- Writes:
  - Any CTRL write clears irq_flag.
  - A CTRL write in the same cycle as the INT-state EN clear: the bus write wins entirely.
  - A PRESET write during CNT does not affect the running COUNT; it is used at the next LOAD.
- Disable mid-count: clearing EN leaves COUNT frozen. Re-enabling goes through LOAD, so COUNT restarts from PRESET rather than resuming.
- irq timing: combinational from registered state; no extra latency. Clearing IM masks irq without clearing irq_flag.
- Reset asserted mid-count forces all reset values on that edge; reset has priority over we.

Optional Feature:
- Macro: TIMER_IRQ_ACK_EN.
- Defined: any write to offset 2 (COUNT) clears irq_flag; COUNT itself stays unchanged. A COUNT write and a flag set in the same cycle: the set wins.
- Undefined: writes to offset 2 are fully ignored; irq_flag clears only via a CTRL write, mode-1 INT, or reset.

Decomposition:
- Package timer_pkg holds:
  - the state encoding (IDLE=0, LOAD=1, CNT=2, INT=3);
  - register offsets (CTRL=0, PRESET=1, COUNT=2);
  - CTRL bit positions (EN=0, MODE=2:1, IM=3);
  - mode codes (ONESHOT=0, RELOAD=1).
- No sub-module: FSM, registers and read mux fit in a single module. The read mux may be a local function.

Test Plan:
- Reset, then read all four offsets → dout=0 each; irq=0.
- Write PRESET=5, then CTRL=0x9 (EN, mode0, IM) → COUNT reads 5,4,3,2,1,0 on successive cycles. irq rises 7 cycles after the CTRL write edge and stays high; CTRL reads 0x8. A CTRL write of 0x8 drops irq the next cycle.
- Write PRESET=3, then CTRL=0xB (mode1, IM) → irq is a 1-cycle pulse every 6 cycles for at least 3 periods; COUNT reloads to 3 each period.
- Mode0 running with PRESET=10: clear EN when COUNT=6 → COUNT holds 6 for 20 cycles. Set EN → COUNT=10 two cycles later.
- Write COUNT=0x1234 → COUNT is unchanged. With TIMER_IRQ_ACK_EN defined and a mode0 irq pending, the same write drops irq; with the macro undefined, irq stays high.
- Assert reset while COUNT=7 in CNT with we=1 to CTRL in the same cycle → all registers 0, state IDLE, irq=0 next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings for timer_counter: FSM states, register offsets, CTRL fields, mode codes.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with level interrupt.
// Optional macro TIMER_IRQ_ACK_EN: a write to the COUNT offset acknowledges irq_flag.
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic [3:0]       r_ctrl;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_irq_flag;
  state_t           r_state;

  logic             w_en;
  logic [1:0]       w_mode;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_en     = r_ctrl[CTRL_EN];
  assign w_mode   = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign w_unused = ^{addr[29:2], din};

`ifdef TIMER_IRQ_ACK_EN
  logic w_flag_set;
  assign w_flag_set = (r_state == ST_CNT) && w_en && (r_count <= CNT_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
      r_state    <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_en) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!w_en) begin
            r_state <= ST_IDLE;
          end else if (r_count > CNT_W'(1)) begin
            r_count <= r_count - CNT_W'(1);
          end else begin
            r_count    <= '0;
            r_irq_flag <= 1'b1;
            r_state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (w_mode == MODE_RELOAD) r_irq_flag <= 1'b0;
          else                       r_ctrl[CTRL_EN] <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Bus writes are placed last so they override any FSM update to the same register.
      if (we) begin
        case (addr[1:0])
          OFF_CTRL: begin
            r_ctrl     <= din[3:0];
            r_irq_flag <= 1'b0;
          end
          OFF_PRESET: r_preset <= din[CNT_W-1:0];
          OFF_COUNT: begin
`ifdef TIMER_IRQ_ACK_EN
            if (!w_flag_set) r_irq_flag <= 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (addr[1:0])
      OFF_CTRL:   w_rdata[3:0]       = r_ctrl;
      OFF_PRESET: w_rdata[CNT_W-1:0] = r_preset;
      OFF_COUNT:  w_rdata[CNT_W-1:0] = r_count;
      default:    w_rdata            = '0;
    endcase
  end

  assign dout = w_rdata;
  assign irq  = r_irq_flag & r_ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized traffic vs a schedule-based model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_counter #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Reference model: timeline measured in edges since the timer was seen enabled while idle.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  bit          m_active;
  int          m_t;
  int unsigned m_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit w, input logic [1:0] a, input logic [31:0] d);
    bit set_now;
    int unsigned n_eff;
    set_now = 1'b0;
    if (rst) begin
      m_ctrl = '0; m_preset = '0; m_count = '0;
      m_flag = 1'b0; m_active = 1'b0; m_t = 0;
      return;
    end
    if (!m_active) begin
      if (m_ctrl[0]) begin
        m_active = 1'b1;
        m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == 1) begin
        m_n = m_preset;
        m_count = m_preset;
      end else begin
        n_eff = (m_n == 0) ? 1 : m_n;
        if (m_t <= int'(n_eff) + 1) begin
          if (!m_ctrl[0]) m_active = 1'b0;
          else if (m_t < int'(n_eff) + 1) m_count = m_n - (m_t - 1);
          else begin
            m_count = 0;
            m_flag  = 1'b1;
            set_now = 1'b1;
          end
        end else begin
          if (m_ctrl[2:1] == 2'd1) m_flag = 1'b0;
          else m_ctrl[0] = 1'b0;
          m_active = 1'b0;
        end
      end
    end
    if (w) begin
      case (a)
        2'd0: begin m_ctrl = d[3:0]; m_flag = 1'b0; end
        2'd1: m_preset = d;
        2'd2: begin
`ifdef TIMER_IRQ_ACK_EN
          if (!set_now) m_flag = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  endtask

  // One clock: drive a bus op, step the model at the edge, then read back offset rd and compare.
  task automatic cycle(input bit rst, input bit w, input logic [1:0] a, input logic [31:0] d,
                       input logic [1:0] rd);
    reset = rst;
    we    = w;
    addr  = {28'd0, a};
    din   = d;
    @(posedge clk);
    model_step(rst, w, a, d);
    #1;
    reset = 1'b0;
    we    = 1'b0;
    addr  = {28'd0, rd};
    #1;
    check_eq("model_dout", dout, m_read(rd));
    check_eq("model_irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
  endtask

  task automatic idle(input logic [1:0] rd);
    cycle(1'b0, 1'b0, 2'd0, 32'd0, rd);
  endtask

  initial begin
    logic [31:0] exp_irq_ack;
    m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 0; m_active = 0; m_t = 0; m_n = 0;

    // Reset, then every offset reads zero.
    cycle(1'b1, 1'b0, 2'd0, 32'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      idle(2'(i));
      check_eq("reset_dout", dout, 32'd0);
      check_eq("reset_irq", {31'd0, irq}, 32'd0);
    end

    // One-shot, PRESET=5: COUNT 5..0 at E2..E7, irq from E7.
    cycle(1'b0, 1'b1, 2'd1, 32'd5, 2'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'h9, 2'd2);
    for (int e = 1; e <= 8; e++) begin
      idle(2'd2);
      if (e >= 2 && e <= 7) check_eq("oneshot_count", dout, 32'(7 - e));
      check_eq("oneshot_irq", {31'd0, irq}, {31'd0, e >= 7});
    end
    idle(2'd0);
    check_eq("oneshot_ctrl", dout, 32'h8);
    check_eq("oneshot_irq_hold", {31'd0, irq}, 32'd1);
    cycle(1'b0, 1'b1, 2'd0, 32'h8, 2'd0);
    check_eq("ctrl_clear_irq", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: period 6, irq pulse at E5, E11, E17, ...
    cycle(1'b0, 1'b1, 2'd1, 32'd3, 2'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'hB, 2'd2);
    for (int e = 1; e <= 22; e++) begin
      idle(2'd2);
      check_eq("reload_irq", {31'd0, irq}, {31'd0, (e >= 5) && ((e - 5) % 6 == 0)});
      if (e >= 2 && (e - 2) % 6 == 0) check_eq("reload_count", dout, 32'd3);
    end
    cycle(1'b0, 1'b1, 2'd0, 32'h0, 2'd2);
    for (int i = 0; i < 8; i++) idle(2'd2);

    // Disable mid-count at COUNT=6, hold, then restart from PRESET.
    cycle(1'b0, 1'b1, 2'd1, 32'd10, 2'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'h9, 2'd2);
    for (int e = 1; e <= 5; e++) idle(2'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'h8, 2'd2);
    check_eq("disable_count", dout, 32'd6);
    for (int i = 0; i < 20; i++) begin
      idle(2'd2);
      check_eq("frozen_count", dout, 32'd6);
    end
    cycle(1'b0, 1'b1, 2'd0, 32'h9, 2'd2);
    idle(2'd2);
    idle(2'd2);
    check_eq("restart_count", dout, 32'd10);
    cycle(1'b0, 1'b1, 2'd0, 32'h0, 2'd2);
    for (int i = 0; i < 4; i++) idle(2'd2);

    // COUNT write with a pending one-shot irq.
    cycle(1'b0, 1'b1, 2'd1, 32'd2, 2'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'h9, 2'd2);
    for (int e = 1; e <= 6; e++) idle(2'd2);
    check_eq("ack_pending_irq", {31'd0, irq}, 32'd1);
    cycle(1'b0, 1'b1, 2'd2, 32'h1234, 2'd2);
    check_eq("count_write_ignored", dout, 32'd0);
`ifdef TIMER_IRQ_ACK_EN
    exp_irq_ack = 32'd0;
`else
    exp_irq_ack = 32'd1;
`endif
    check_eq("count_write_irq", {31'd0, irq}, exp_irq_ack);
    cycle(1'b0, 1'b1, 2'd0, 32'h0, 2'd2);

    // Reset mid-count with a simultaneous CTRL write.
    cycle(1'b0, 1'b1, 2'd1, 32'd10, 2'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'h9, 2'd2);
    for (int e = 1; e <= 5; e++) idle(2'd2);
    check_eq("pre_reset_count", dout, 32'd7);
    cycle(1'b1, 1'b1, 2'd0, 32'hF, 2'd2);
    check_eq("midreset_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(2'(i));
      check_eq("midreset_dout", dout, 32'd0);
    end
    idle(2'd2);
    check_eq("midreset_idle_count", dout, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst;
      bit          r_w;
      logic [1:0]  r_a;
      logic [31:0] r_d;
      r_rst = ($urandom_range(0, 199) == 0);
      r_w   = ($urandom_range(0, 99) < 15);
      r_a   = 2'($urandom_range(0, 3));
      r_d   = $urandom;
      if (r_a == 2'd1) r_d = $urandom_range(0, 9);
      if (r_a == 2'd0 && $urandom_range(0, 3) != 0) r_d[0] = 1'b1;
      cycle(r_rst, r_w, r_a, r_d, 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
